// File: rtl/zx_mem_pkg.sv
// Shared constants, paging-register layout and write-FSM states for the Spectrum memory pager.
// The +3 paging helpers are only referenced when ZX_PLUS3_PAGING_EN is defined.
package zx_mem_pkg;

  localparam logic [2:0] BANK_SCREEN0 = 3'd5;
  localparam logic [2:0] BANK_SCREEN1 = 3'd7;
  localparam logic [2:0] BANK_SLOT2   = 3'd2;

  // Partial port decodes: only the masked address bits take part in the match.
  localparam logic [15:0] PORT_7FFD_MASK  = 16'h8002;
  localparam logic [15:0] PORT_7FFD_MATCH = 16'h0000;
  localparam logic [15:0] PORT_1FFD_MASK  = 16'hF002;
  localparam logic [15:0] PORT_1FFD_MATCH = 16'h1000;

  localparam int unsigned PG_BANK_LSB = 0;
  localparam int unsigned PG_SCREEN   = 3;
  localparam int unsigned PG_ROM      = 4;
  localparam int unsigned PG_LOCK     = 5;

  localparam int unsigned P3_SPECIAL  = 0;
  localparam int unsigned P3_CFG_LSB  = 1;
  localparam int unsigned P3_ROM_HI   = 2;

  typedef enum logic [1:0] {
    StIdle,
    StWrPulse,
    StWrHold
  } wr_state_e;

  function automatic logic port_hit(input logic [15:0] addr, input logic [15:0] mask,
                                    input logic [15:0] match);
    return (addr & mask) == match;
  endfunction

  // All-RAM configurations: {0,1,2,3}, {4,5,6,7}, {4,5,6,3}, {4,7,6,3}.
  function automatic logic [2:0] special_bank(input logic [1:0] cfg, input logic [1:0] slot);
    logic [2:0] bank;
    bank = {1'b0, slot};
    unique case (cfg)
      2'd0: bank = {1'b0, slot};
      2'd1: bank = {1'b1, slot};
      2'd2: bank = (slot == 2'd3) ? 3'd3 : {1'b1, slot};
      2'd3: begin
        unique case (slot)
          2'd0: bank = 3'd4;
          2'd1: bank = 3'd7;
          2'd2: bank = 3'd6;
          default: bank = 3'd3;
        endcase
      end
      default: bank = {1'b0, slot};
    endcase
    return bank;
  endfunction

endpackage

// File: rtl/zx_strobe_edge.sv
// Registers an active-low CPU strobe and emits a one-cycle pulse on its falling edge.
// After reset the strobe must be seen high once before a falling edge can be reported.
module zx_strobe_edge (
  input  logic clk_i,
  input  logic reset_i,
  input  logic strobe_ni,
  output logic fall_o
);

  logic strobe_q;
  logic armed_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      strobe_q <= 1'b1;
      armed_q  <= 1'b0;
    end else begin
      strobe_q <= strobe_ni;
      armed_q  <= armed_q | strobe_ni;
    end
  end

  // Without the arm bit a strobe still low when reset releases would look like a new edge.
  always_comb begin
    fall_o = armed_q & strobe_q & ~strobe_ni & ~reset_i;
  end

endmodule

// File: rtl/zx_mem_pager.sv
// 128K-class memory map and 0x7FFD paging controller for synchronous block RAM/ROM.
// Define ZX_PLUS3_PAGING_EN to add the 0x1FFD special/all-RAM paging and a 16-bit rom_addr.
module zx_mem_pager
  import zx_mem_pkg::*;
#(
  parameter int unsigned RAM_BANKS     = 8,
  parameter int unsigned ROM_PAGES     = 2,
  parameter logic [7:0]  UNMAPPED_DATA = 8'hFF
) (
  input  logic        clk_vram,
  input  logic        reset,
  input  logic [15:0] A,
  input  logic [7:0]  D_in,
  input  logic        nMREQ,
  input  logic        nIORQ,
  input  logic        nRD,
  input  logic        nWR,
  input  logic        nM1,
  output logic [16:0] mem_addr,
`ifdef ZX_PLUS3_PAGING_EN
  output logic [15:0] rom_addr,
`else
  output logic [14:0] rom_addr,
`endif
  output logic        ram_we,
  output logic        sel_rom,
  output logic        sel_ram,
  output logic        rd_unmapped,
  output logic        screen_bank,
  output logic [7:0]  page_reg
);

  logic [7:0] page_q;
  logic       ram_we_q;
  wr_state_e  state_q;
  logic       wr_fall;
  logic       lock;
  logic       io_wr;
  logic       pg_7ffd_wr;
  logic       mem_wr;
  logic [1:0] slot;
  logic [2:0] bank;
  logic       is_rom;
  logic       bank_ok;
  logic       rom_lo;

  // UNMAPPED_DATA is consumed by the top-level read mux; D_in[7:6] have no register home.
  logic       unused_bits;
  assign unused_bits = ^{D_in[7:6], UNMAPPED_DATA};

  zx_strobe_edge u_wr_edge (
    .clk_i    (clk_vram),
    .reset_i  (reset),
    .strobe_ni(nWR),
    .fall_o   (wr_fall)
  );

  assign lock = page_q[PG_LOCK];
  assign slot = A[15:14];

`ifdef ZX_PLUS3_PAGING_EN
  logic [2:0] p3_q;
  logic       pg_1ffd_wr;
  logic       rom_hi;

  always_comb begin
    pg_1ffd_wr = io_wr & port_hit(A, PORT_1FFD_MASK, PORT_1FFD_MATCH);
    rom_hi     = (ROM_PAGES > 2) ? p3_q[P3_ROM_HI] : 1'b0;
  end
`endif

  always_comb begin
    io_wr      = wr_fall & ~nIORQ & nM1;
    mem_wr     = wr_fall & ~nMREQ & nIORQ;
    pg_7ffd_wr = io_wr & port_hit(A, PORT_7FFD_MASK, PORT_7FFD_MATCH);
`ifdef ZX_PLUS3_PAGING_EN
    pg_7ffd_wr = pg_7ffd_wr & ~port_hit(A, PORT_1FFD_MASK, PORT_1FFD_MATCH);
`endif
  end

  always_comb begin
    is_rom = (slot == 2'd0);
    bank   = 3'd0;
    unique case (slot)
      2'd1:    bank = BANK_SCREEN0;
      2'd2:    bank = BANK_SLOT2;
      2'd3:    bank = page_q[PG_BANK_LSB +: 3];
      default: bank = 3'd0;
    endcase
`ifdef ZX_PLUS3_PAGING_EN
    if (p3_q[P3_SPECIAL]) begin
      is_rom = 1'b0;
      bank   = special_bank(p3_q[P3_CFG_LSB +: 2], slot);
    end
`endif
    bank_ok = ({29'd0, bank} < RAM_BANKS);
    rom_lo  = (ROM_PAGES > 1) ? page_q[PG_ROM] : 1'b0;
  end

  always_comb begin
    mem_addr    = {bank, A[13:0]};
`ifdef ZX_PLUS3_PAGING_EN
    rom_addr    = {rom_hi, rom_lo, A[13:0]};
`else
    rom_addr    = {rom_lo, A[13:0]};
`endif
    sel_rom     = reset | is_rom;
    sel_ram     = ~reset & ~is_rom;
    rd_unmapped = ~reset & ~is_rom & ~bank_ok & ~nMREQ & ~nRD;
    ram_we      = ram_we_q;
    screen_bank = page_q[PG_SCREEN];
    page_reg    = page_q;
  end

  always_ff @(posedge clk_vram) begin
    if (reset) begin
      state_q  <= StIdle;
      ram_we_q <= 1'b0;
      page_q   <= 8'h00;
`ifdef ZX_PLUS3_PAGING_EN
      p3_q     <= 3'b000;
`endif
    end else begin
      ram_we_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (mem_wr) begin
            state_q  <= StWrPulse;
            ram_we_q <= ~is_rom & bank_ok;
          end
        end
        StWrPulse: state_q <= StWrHold;
        StWrHold: begin
          if (nWR) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase

      // Once locked, page writes are dropped, so lock can only clear through reset.
      if (pg_7ffd_wr && !lock) begin
        page_q <= {2'b00, D_in[5:0]};
      end
`ifdef ZX_PLUS3_PAGING_EN
      if (pg_1ffd_wr && !lock) begin
        p3_q <= D_in[2:0];
      end
`endif
    end
  end

endmodule

// File: tb/tb_zx_mem_pager.sv
// Directed bench for zx_mem_pager: a full-size instance and a 2-bank/1-ROM-page instance
// share the same bus stimulus.
module tb_zx_mem_pager;
  import zx_mem_pkg::*;

  logic        clk_vram = 1'b0;
  logic        reset    = 1'b1;
  logic [15:0] A        = 16'h0000;
  logic [7:0]  D_in     = 8'h00;
  logic        nMREQ    = 1'b1;
  logic        nIORQ    = 1'b1;
  logic        nRD      = 1'b1;
  logic        nWR      = 1'b1;
  logic        nM1      = 1'b1;

  logic [16:0] mem_addr, mem_addr2;
`ifdef ZX_PLUS3_PAGING_EN
  logic [15:0] rom_addr, rom_addr2;
`else
  logic [14:0] rom_addr, rom_addr2;
`endif
  logic        ram_we, sel_rom, sel_ram, rd_unmapped, screen_bank;
  logic        ram_we2, sel_rom2, sel_ram2, rd_unmapped2, screen_bank2;
  logic [7:0]  page_reg, page_reg2;

  int n_cmp  = 0;
  int n_fail = 0;
  int we1    = 0;
  int we2    = 0;
  int base1, base2;
  logic [16:0] we1_addr = '0;

  zx_mem_pager u_dut (
    .clk_vram(clk_vram), .reset(reset), .A(A), .D_in(D_in),
    .nMREQ(nMREQ), .nIORQ(nIORQ), .nRD(nRD), .nWR(nWR), .nM1(nM1),
    .mem_addr(mem_addr), .rom_addr(rom_addr), .ram_we(ram_we),
    .sel_rom(sel_rom), .sel_ram(sel_ram), .rd_unmapped(rd_unmapped),
    .screen_bank(screen_bank), .page_reg(page_reg)
  );

  zx_mem_pager #(.RAM_BANKS(2), .ROM_PAGES(1), .UNMAPPED_DATA(8'hFF)) u_dut2 (
    .clk_vram(clk_vram), .reset(reset), .A(A), .D_in(D_in),
    .nMREQ(nMREQ), .nIORQ(nIORQ), .nRD(nRD), .nWR(nWR), .nM1(nM1),
    .mem_addr(mem_addr2), .rom_addr(rom_addr2), .ram_we(ram_we2),
    .sel_rom(sel_rom2), .sel_ram(sel_ram2), .rd_unmapped(rd_unmapped2),
    .screen_bank(screen_bank2), .page_reg(page_reg2)
  );

  always #5 clk_vram = ~clk_vram;

  always @(negedge clk_vram) begin
    if (ram_we) begin
      we1      <= we1 + 1;
      we1_addr <= mem_addr;
    end
    if (ram_we2) we2 <= we2 + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mem_read(input logic [15:0] addr);
    @(negedge clk_vram);
    A = addr; nMREQ = 1'b0; nRD = 1'b0; nIORQ = 1'b1; nWR = 1'b1;
    #1;
  endtask

  task automatic bus_release();
    nMREQ = 1'b1; nRD = 1'b1; nIORQ = 1'b1; nWR = 1'b1; nM1 = 1'b1;
  endtask

  task automatic io_write(input logic [15:0] addr, input logic [7:0] data, input logic m1);
    @(negedge clk_vram);
    bus_release();
    A = addr; D_in = data; nM1 = m1; nIORQ = 1'b0; nWR = 1'b0;
    @(negedge clk_vram);
    bus_release();
    @(negedge clk_vram);
    #1;
  endtask

  task automatic mem_write(input logic [15:0] addr, input int hold);
    @(negedge clk_vram);
    bus_release();
    A = addr; nMREQ = 1'b0; nWR = 1'b0;
    repeat (hold) @(negedge clk_vram);
    bus_release();
    repeat (2) @(negedge clk_vram);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk_vram);
    bus_release();
    reset = 1'b1;
    repeat (2) @(negedge clk_vram);
    reset = 1'b0;
    repeat (2) @(negedge clk_vram);
    #1;
  endtask

  initial begin
    repeat (3) @(negedge clk_vram);
    reset = 1'b0;
    repeat (2) @(negedge clk_vram);
    #1;
    check("rst_page_reg", 32'(page_reg), 32'h00);
    check("rst_ram_we", 32'(ram_we), 32'h0);
    check("rst_sel_rom", 32'(sel_rom), 32'h1);
    check("rst_sel_ram", 32'(sel_ram), 32'h0);
    check("rst_rd_unmapped", 32'(rd_unmapped), 32'h0);
    check("rst_screen_bank", 32'(screen_bank), 32'h0);

    mem_read(16'h0000);
    check("rd0000_sel_rom", 32'(sel_rom), 32'h1);
    check("rd0000_rom_addr", 32'(rom_addr), 32'h0000);
    mem_read(16'h4000);
    check("rd4000_sel_ram", 32'(sel_ram), 32'h1);
    check("rd4000_mem_addr", 32'(mem_addr), 32'h14000);
    mem_read(16'hC000);
    check("rdC000_mem_addr", 32'(mem_addr), 32'h00000);
    bus_release();

    io_write(16'h7FFD, 8'h17, 1'b1);
    check("out17_page_reg", 32'(page_reg), 32'h17);
    mem_read(16'hC123);
    check("rdC123_mem_addr", 32'(mem_addr), 32'h1C123);
    check("rdC123_screen", 32'(screen_bank), 32'h0);
    check("rdC123_unmapped", 32'(rd_unmapped), 32'h0);
    check("b2_rdC123_unmapped", 32'(rd_unmapped2), 32'h1);
    check("b2_rdC123_mem_addr", 32'(mem_addr2), 32'h1C123);
    mem_read(16'h0000);
    check("rom_page1_addr", 32'(rom_addr), 32'h4000);
    check("b2_rom_page_forced0", 32'(rom_addr2), 32'h0000);
    bus_release();

    io_write(16'h7FFD, 8'h08, 1'b1);
    check("out08_screen", 32'(screen_bank), 32'h1);
    io_write(16'h7FFD, 8'h03, 1'b0);
    check("intack_no_write", 32'(page_reg), 32'h08);
    io_write(16'h7FFF, 8'h03, 1'b1);
    check("a1_high_ignored", 32'(page_reg), 32'h08);

    io_write(16'h7FFD, 8'h20, 1'b1);
    check("lock_page_reg", 32'(page_reg), 32'h20);
    io_write(16'h7FFD, 8'h07, 1'b1);
    check("locked_ignored", 32'(page_reg), 32'h20);
    do_reset();
    check("reset_unlocks", 32'(page_reg), 32'h00);
    io_write(16'h7FFD, 8'h07, 1'b1);
    check("after_reset_write", 32'(page_reg), 32'h07);

    io_write(16'h7FFD, 8'h03, 1'b1);
    mem_read(16'hC000);
    check("p3_rdC000_mapped", 32'(rd_unmapped), 32'h0);
    check("p3_rdC000_mem_addr", 32'(mem_addr), 32'h0C000);
    check("b2_p3_rdC000_unmapped", 32'(rd_unmapped2), 32'h1);
    bus_release();

    base1 = we1; base2 = we2;
    mem_write(16'h8000, 6);
    check("wr8000_one_pulse", 32'(we1 - base1), 32'd1);
    check("wr8000_addr", 32'(we1_addr), 32'h08000);
    check("b2_wr8000_no_pulse", 32'(we2 - base2), 32'd0);
    check("wr8000_we_low", 32'(ram_we), 32'h0);

    base1 = we1; base2 = we2;
    mem_write(16'hC000, 2);
    check("wrC000_one_pulse", 32'(we1 - base1), 32'd1);
    check("wrC000_addr", 32'(we1_addr), 32'h0C000);
    check("b2_wrC000_unmapped", 32'(we2 - base2), 32'd0);

    base1 = we1;
    mem_write(16'h1000, 2);
    check("wr1000_rom_ignored", 32'(we1 - base1), 32'd0);

    base1 = we1; base2 = we2;
    mem_write(16'h4000, 1);
    check("wr4000_short_pulse", 32'(we1 - base1), 32'd1);
    check("wr4000_addr", 32'(we1_addr), 32'h14000);
    check("b2_wr4000_no_pulse", 32'(we2 - base2), 32'd0);

    base1 = we1;
    @(negedge clk_vram);
    A = 16'h8000; nMREQ = 1'b0; nWR = 1'b0; reset = 1'b1;
    repeat (3) @(negedge clk_vram);
    reset = 1'b0;
    repeat (4) @(negedge clk_vram);
    #1;
    check("rst_midwrite_no_pulse", 32'(we1 - base1), 32'd0);
    check("rst_midwrite_idle", 32'(u_dut.state_q), 32'(StIdle));
    bus_release();
    repeat (2) @(negedge clk_vram);
    base1 = we1;
    mem_write(16'h8000, 3);
    check("post_rst_write_pulse", 32'(we1 - base1), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
